psum_accumulator: RTL

- Downstream consumer of the output psum FIFO; drains one row (col psums) per read and accumulates rows into an on-chip accumulation buffer across cfg_pass passes.
- Each pass covers cfg_len output positions; pass 0 overwrites, later passes add.
- After the final pass, it streams each accumulated row out on a valid/ready port, with optional ReLU, then pulses done.

---
 rtl/psum_acc_pkg.sv | 23 ++
 rtl/psum_acc_lane.sv | 44 ++++
 rtl/psum_accumulator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared constants and FSM state encoding for psum_accumulator.
//   PSUM_BW / ACC_BW : default signed widths of incoming psum lanes and accumulator lanes
//   COL, ACC_DEPTH, ADDR_BW, RD_LAT : default geometry and FIFO read latency
//   state_e          : controller states IDLE..FIN
package psum_acc_pkg;

  localparam int unsigned PSUM_BW   = 16;
  localparam int unsigned ACC_BW    = 20;
  localparam int unsigned COL       = 8;
  localparam int unsigned ACC_DEPTH = 16;
  localparam int unsigned ADDR_BW   = 4;
  localparam int unsigned RD_LAT    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_ACC,
    S_DRAIN,
    S_FIN
  } state_e;

endpackage

// File: rtl/psum_acc_lane.sv
// psum_acc_lane: one accumulator lane, purely combinational.
//   psum_i      : signed incoming psum
//   acc_i       : signed stored accumulator value for this lane
//   overwrite_i : 1 = first pass, ignore acc_i
//   sum_o       : saturated (overwrite ? 0 : acc_i) + sign_extend(psum_i)
//   post_o      : drain value of acc_i; max(acc_i,0) when PSUM_ACC_RELU_EN is defined,
//                 raw acc_i otherwise
module psum_acc_lane
  import psum_acc_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned acc_bw  = ACC_BW
) (
  input  logic signed [psum_bw-1:0] psum_i,
  input  logic signed [acc_bw-1:0]  acc_i,
  input  logic                      overwrite_i,
  output logic signed [acc_bw-1:0]  sum_o,
  output logic signed [acc_bw-1:0]  post_o
);

  logic signed [acc_bw:0] base;
  logic signed [acc_bw:0] ext;
  logic signed [acc_bw:0] wide;

  always_comb begin
    base = overwrite_i ? '0 : {acc_i[acc_bw-1], acc_i};
    ext  = {{(acc_bw + 1 - psum_bw){psum_i[psum_bw-1]}}, psum_i};
    wide = base + ext;
    // One guard bit suffices: top two bits disagree only on overflow,
    // and the guard bit gives the true sign to clamp towards.
    if (wide[acc_bw] != wide[acc_bw-1]) begin
      sum_o = wide[acc_bw] ? {1'b1, {(acc_bw - 1){1'b0}}} : {1'b0, {(acc_bw - 1){1'b1}}};
    end else begin
      sum_o = wide[acc_bw-1:0];
    end
  end

`ifdef PSUM_ACC_RELU_EN
  assign post_o = acc_i[acc_bw-1] ? '0 : acc_i;
`else
  assign post_o = acc_i;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: drains psum rows from the output FIFO, accumulates them over
// cfg_pass passes of cfg_len rows, then streams the accumulated rows out.
//   clk, reset        : clock, synchronous active-high reset
//   start             : job start pulse (ignored while busy)
//   cfg_len, cfg_pass : rows per pass, number of passes (sampled on accepted start)
//   ofifo_valid/rd/out: FIFO row-available, one-cycle read request, row data (rd_lat later)
//   out_valid/ready/data : result row stream, valid/ready handshake
//   busy, done        : not-idle flag, one-cycle completion pulse
// Optional macro PSUM_ACC_RELU_EN: clamp drained lanes at zero.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int unsigned col       = COL,
  parameter int unsigned psum_bw   = PSUM_BW,
  parameter int unsigned acc_bw    = ACC_BW,
  parameter int unsigned acc_depth = ACC_DEPTH,
  parameter int unsigned addr_bw   = ADDR_BW,
  parameter int unsigned rd_lat    = RD_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [addr_bw:0]          cfg_len,
  input  logic [7:0]                cfg_pass,
  input  logic                      ofifo_valid,
  output logic                      ofifo_rd,
  input  logic [psum_bw*col-1:0]    ofifo_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [acc_bw*col-1:0]     out_data,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned WAIT_BW = (rd_lat > 2) ? $clog2(rd_lat - 1) : 1;
  localparam logic [WAIT_BW-1:0] WAIT_LAST = WAIT_BW'((rd_lat > 1) ? rd_lat - 2 : 0);

  state_e                 state_q, state_d;
  logic [addr_bw:0]       addr_q, addr_d;
  logic [addr_bw:0]       len_q, len_d;
  logic [7:0]             pass_q, pass_d;
  logic [7:0]             npass_q, npass_d;
  logic [WAIT_BW-1:0]     wait_q, wait_d;
  logic                   out_valid_q, out_valid_d;
  logic [acc_bw*col-1:0]  out_data_q, out_data_d;
  logic                   acc_we;
  logic                   rd_req;

  logic [acc_bw*col-1:0]  buf_q [acc_depth];
  logic [acc_bw*col-1:0]  row_rd;
  logic [acc_bw*col-1:0]  sum_row;
  logic [acc_bw*col-1:0]  post_row;
  logic [addr_bw:0]       addr_inc;

  assign row_rd   = buf_q[addr_q[addr_bw-1:0]];
  assign addr_inc = addr_q + 1'b1;

  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_acc_lane #(
      .psum_bw (psum_bw),
      .acc_bw  (acc_bw)
    ) u_lane (
      .psum_i      (ofifo_out[g*psum_bw +: psum_bw]),
      .acc_i       (row_rd[g*acc_bw +: acc_bw]),
      .overwrite_i (pass_q == 8'd0),
      .sum_o       (sum_row[g*acc_bw +: acc_bw]),
      .post_o      (post_row[g*acc_bw +: acc_bw])
    );
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    pass_d      = pass_q;
    npass_d     = npass_q;
    wait_d      = wait_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_we      = 1'b0;
    rd_req      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          npass_d = cfg_pass;
          addr_d  = '0;
          pass_d  = '0;
          state_d = (cfg_len == '0 || cfg_pass == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (ofifo_valid) begin
          rd_req  = 1'b1;
          wait_d  = '0;
          state_d = (rd_lat > 1) ? S_WAIT : S_ACC;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_ACC;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ACC: begin
        acc_we = 1'b1;
        if (addr_inc == len_q) begin
          addr_d  = '0;
          pass_d  = pass_q + 8'd1;
          state_d = ((pass_q + 8'd1) == npass_q) ? S_DRAIN : S_READ;
        end else begin
          addr_d  = addr_inc;
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        // Load a row, then hold it until accepted; one idle cycle follows each handshake.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = post_row;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (addr_inc == len_q) begin
            addr_d  = '0;
            state_d = S_FIN;
          end else begin
            addr_d = addr_inc;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      pass_q      <= '0;
      npass_q     <= '0;
      wait_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      pass_q      <= pass_d;
      npass_q     <= npass_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Buffer is never cleared: pass 0 overwrites. Reset still blocks a pending write.
  always_ff @(posedge clk) begin
    if (!reset && acc_we) begin
      buf_q[addr_q[addr_bw-1:0]] <= sum_row;
    end
  end

  assign ofifo_rd  = rd_req;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

endmodule
